moa_8x8_operand_feeder: RTL and testbench

- Upstream feeder for the 8-operand, 8-bit multi-operand adder, which has fixed 2-cycle latency, no stall and no valid signal.
- Accepts a serial stream of operands over a valid/ready handshake and groups them 8 at a time, or fewer when terminated early by in_last.
- Launches each group in parallel onto x0..x7 and tracks the adder latency.
- Captures the adder's 11-bit result into a small result FIFO presented on a valid/ready interface. Credit control guarantees no in-flight result is ever lost.

---
 rtl/moa_pkg.sv | 8 +
 rtl/moa_res_fifo.sv | 45 ++++
 rtl/moa_8x8_operand_feeder.sv | 130 +++++++++++++
 tb/tb_moa_8x8_operand_feeder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/moa_pkg.sv
// Shared constants for the 8-operand multi-operand adder feeder.
package moa_pkg;
  localparam int MOA_W   = 8;
  localparam int MOA_SW  = 11;
  localparam int MOA_N   = 8;
  localparam int MOA_LAT = 2;
  localparam int CNT_W   = 4;
endpackage

// File: rtl/moa_res_fifo.sv
// Result FIFO holding {operand count, sum} pairs; head reads as zero when empty.
module moa_res_fifo #(
  parameter int D  = 4,
  parameter int SW = 11,
  parameter int CW = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [SW-1:0]       push_sum,
  input  logic [CW-1:0]       push_count,
  input  logic                pop,
  output logic [SW-1:0]       head_sum,
  output logic [CW-1:0]       head_count,
  output logic [$clog2(D):0]  fifo_count,
  output logic                empty,
  output logic                full
);
  localparam int AW = $clog2(D);
  localparam int FW = AW + 1;

  logic [CW+SW-1:0] mem [D];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(push);
      rd_ptr     <= rd_ptr + AW'(pop);
      fifo_count <= fifo_count + FW'(push) - FW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_count, push_sum};
  end

  assign empty = (fifo_count == '0);
  assign full  = (fifo_count == FW'(D));
  assign {head_count, head_sum} = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/moa_8x8_operand_feeder.sv
// Groups a serial operand stream into up to 8 parallel adder operands and
// collects the fixed-latency adder results into a credit-protected FIFO.
module moa_8x8_operand_feeder
  import moa_pkg::*;
#(
  parameter int W   = MOA_W,
  parameter int SW  = MOA_SW,
  parameter int LAT = MOA_LAT,
  parameter int D   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic [W-1:0]     x0,
  output logic [W-1:0]     x1,
  output logic [W-1:0]     x2,
  output logic [W-1:0]     x3,
  output logic [W-1:0]     x4,
  output logic [W-1:0]     x5,
  output logic [W-1:0]     x6,
  output logic [W-1:0]     x7,
  input  logic [SW-1:0]    moa_summ,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SW-1:0]    res_sum,
  output logic [CNT_W-1:0] res_count
);
  localparam int FCW   = $clog2(D) + 1;
  localparam int IDX_W = $clog2(MOA_N);

  logic [W-1:0]     opnd_buf [MOA_N];
  logic [W-1:0]     x_q      [MOA_N];
  logic [W-1:0]     x_next   [MOA_N];
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hold_size;
  logic [CNT_W-1:0] grp_size;
  logic             hold;
  logic             accept;
  logic             complete;
  logic             can_launch;
  logic             launch;
  logic [LAT:0]     launch_vld;
  logic [CNT_W-1:0] launch_tag [LAT+1];
  logic [FCW-1:0]   fifo_count;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_full;
  int               inflight;

  assign in_ready = !hold;
  assign accept   = in_valid && in_ready;
  assign complete = accept && (in_last || cnt == CNT_W'(MOA_N - 1));
  assign grp_size = hold ? hold_size : cnt + 1'b1;

  // A same-cycle pop is not credited, so a result can never arrive to a full FIFO.
  always_comb begin
    inflight = 0;
    for (int i = 0; i <= LAT; i++) inflight += int'(launch_vld[i]);
  end

  assign can_launch = !fifo_full && ((int'(fifo_count) + inflight) < D);
  assign launch     = (complete || hold) && can_launch;

  // Slots at or beyond the group size are forced to zero so old operands never leak.
  always_comb begin
    for (int i = 0; i < MOA_N; i++) begin
      x_next[i] = '0;
      if (CNT_W'(i) < grp_size)
        x_next[i] = (!hold && CNT_W'(i) == cnt) ? in_data : opnd_buf[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      hold       <= 1'b0;
      hold_size  <= '0;
      launch_vld <= '0;
      for (int i = 0; i < MOA_N; i++) x_q[i] <= '0;
    end else begin
      launch_vld <= {launch_vld[LAT-1:0], launch};
      if (launch) begin
        cnt  <= '0;
        hold <= 1'b0;
        x_q  <= x_next;
      end else if (complete) begin
        hold      <= 1'b1;
        hold_size <= grp_size;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) opnd_buf[cnt[IDX_W-1:0]] <= in_data;
    launch_tag[0] <= grp_size;
    for (int i = 1; i <= LAT; i++) launch_tag[i] <= launch_tag[i-1];
  end

  assign {x0, x1, x2, x3} = {x_q[0], x_q[1], x_q[2], x_q[3]};
  assign {x4, x5, x6, x7} = {x_q[4], x_q[5], x_q[6], x_q[7]};

  // Stage LAT lines up with the adder output for that launch.
  assign fifo_push = launch_vld[LAT];
  assign fifo_pop  = res_valid && res_ready;
  assign res_valid = !fifo_empty;

  moa_res_fifo #(
    .D (D),
    .SW(SW),
    .CW(CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_sum  (moa_summ),
    .push_count(launch_tag[LAT]),
    .pop       (fifo_pop),
    .head_sum  (res_sum),
    .head_count(res_count),
    .fifo_count(fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );
endmodule

// File: tb/tb_moa_8x8_operand_feeder.sv
// Directed and randomised bench for the operand feeder with a 2-cycle adder model.
module tb_moa_8x8_operand_feeder;
  import moa_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic [7:0]  x0, x1, x2, x3, x4, x5, x6, x7;
  logic [10:0] moa_summ = '0;
  logic [10:0] adder_p1 = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [10:0] res_sum;
  logic [3:0]  res_count;
  logic [7:0]  xv [8];

  int          n_checks = 0;
  int          n_errors = 0;
  int          rr_mode  = 1;
  logic [14:0] exp_q [$];

  always #5 clk = ~clk;

  moa_8x8_operand_feeder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .x0       (x0),
    .x1       (x1),
    .x2       (x2),
    .x3       (x3),
    .x4       (x4),
    .x5       (x5),
    .x6       (x6),
    .x7       (x7),
    .moa_summ (moa_summ),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_sum  (res_sum),
    .res_count(res_count)
  );

  assign xv[0] = x0;
  assign xv[1] = x1;
  assign xv[2] = x2;
  assign xv[3] = x3;
  assign xv[4] = x4;
  assign xv[5] = x5;
  assign xv[6] = x6;
  assign xv[7] = x7;

  // Two-cycle adder: x changes at edge E, moa_summ follows at edge E+2.
  always @(posedge clk) begin
    adder_p1 <= 11'(x0) + 11'(x1) + 11'(x2) + 11'(x3)
              + 11'(x4) + 11'(x5) + 11'(x6) + 11'(x7);
    moa_summ <= adder_p1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drives res_ready, then scores the pop that the coming edge will perform.
  always @(negedge clk) begin
    logic [14:0] e;
    case (rr_mode)
      0:       res_ready = 1'b0;
      1:       res_ready = 1'b1;
      default: res_ready = 1'($urandom_range(0, 1));
    endcase
    if (rst_n === 1'b1) begin
      if (dut.fifo_push)
        chk("fifo_overflow", int'(dut.fifo_full && !(res_valid && res_ready)), 0);
      if (res_valid && res_ready) begin
        chk("result_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("res_sum", int'(res_sum), int'(e[10:0]));
          chk("res_count", int'(res_count), int'(e[14:11]));
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_group(input logic [7:0] ops [$]);
    int s;
    s = 0;
    foreach (ops[i]) begin
      s += int'(ops[i]);
      send(ops[i], i == ops.size() - 1);
    end
    exp_q.push_back({4'(ops.size()), 11'(s)});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_x%0d", tag, i), int'(xv[i]), 0);
    chk({tag, "_res_valid"}, int'(res_valid), 0);
    chk({tag, "_res_sum"}, int'(res_sum), 0);
    chk({tag, "_res_count"}, int'(res_count), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q [$];
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Full group of maximum operands; result appears 3 edges after launch.
    rr_mode = 1;
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(8'd255);
    send_group(q);
    for (int i = 0; i < 8; i++) chk($sformatf("t1_x%0d", i), int'(xv[i]), 255);
    chk("t1_valid_e0", int'(res_valid), 0);
    @(negedge clk);
    chk("t1_valid_e1", int'(res_valid), 0);
    @(negedge clk);
    chk("t1_valid_e2", int'(res_valid), 0);
    @(negedge clk);
    chk("t1_valid_e3", int'(res_valid), 1);
    chk("t1_sum", int'(res_sum), 2040);
    chk("t1_count", int'(res_count), 8);
    drain();

    // Short group after a full one must not see stale operands.
    q = {};
    for (int i = 1; i <= 8; i++) q.push_back(8'(i * 10));
    send_group(q);
    q = {};
    for (int i = 1; i <= 3; i++) q.push_back(8'(i));
    send_group(q);
    for (int i = 0; i < 8; i++) chk($sformatf("t2_x%0d", i), int'(xv[i]), (i < 3) ? i + 1 : 0);
    drain();

    // Back-pressure: four results fill the FIFO, the fifth group is held.
    rr_mode = 0;
    @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      q = {};
      for (int i = 0; i < 8; i++) q.push_back(8'(g * 10 + i));
      send_group(q);
    end
    chk("t3_in_ready_hold", int'(in_ready), 0);
    chk("t3_head_valid", int'(res_valid), 1);
    chk("t3_head_sum", int'(res_sum), 28);
    repeat (5) @(negedge clk);
    chk("t3_in_ready_still", int'(in_ready), 0);
    rr_mode = 1;
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(8'(50 + i));
    send_group(q);
    drain();

    // Single-operand groups back to back.
    for (int v = 0; v < 16; v++) begin
      q = {};
      q.push_back(8'(v));
      send_group(q);
    end
    drain();

    // Asynchronous reset mid-group with pending results.
    rr_mode = 0;
    @(negedge clk);
    q = {};
    q.push_back(8'd3);
    send_group(q);
    q = {};
    q.push_back(8'd4);
    send_group(q);
    for (int i = 0; i < 5; i++) send(8'd9, 1'b0);
    rst_n = 1'b0;
    #1;
    check_idle("t5_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n   = 1'b1;
    rr_mode = 1;
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(8'd1);
    send_group(q);
    drain();
    repeat (8) @(negedge clk);
    chk("t5_no_stale", int'(res_valid), 0);

    // Random group sizes and data with random downstream back-pressure.
    rr_mode = 2;
    for (int g = 0; g < 200; g++) begin
      q = {};
      for (int i = 0; i < int'($urandom_range(1, 8)); i++)
        q.push_back(8'($urandom_range(0, 255)));
      send_group(q);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
